// File: rtl/alu_pkg.sv
// Shared types for the ALU response-capture path: command encoding, capture FSM states and flag bundle.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_XOR  = 3'd2,
    ALU_SLT  = 3'd3,
    ALU_AND  = 3'd4,
    ALU_NAND = 3'd5,
    ALU_NOR  = 3'd6,
    ALU_OR   = 3'd7
  } alu_cmd_e;

  typedef enum logic [1:0] {
    CAP_IDLE   = 2'd0,
    CAP_SETTLE = 2'd1,
    CAP_HOLD   = 2'd2
  } cap_state_e;

  typedef struct packed {
    logic carryout;
    logic zero;
    logic overflow;
  } alu_flags_t;

endpackage

// File: rtl/stability_tracker.sv
// Watches the ALU output vector after a start and reports when it has held still long enough
// or when the settle window has run out.
module stability_tracker
  import alu_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 1024,
  parameter int CNT_W         = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             active,
  input  logic [WIDTH+2:0] vec,
  output logic [WIDTH+2:0] snap_next,
  output logic [CNT_W-1:0] last_change_next,
  output logic             settled,
  output logic             timed_out
);

  localparam int ST_W = $clog2(STABLE_CYCLES + 1);

  logic [WIDTH+2:0] snap_q, snap_d;
  logic [CNT_W-1:0] age_q, age_d;
  logic [CNT_W-1:0] last_change_q, last_change_d;
  logic [ST_W-1:0]  stable_q, stable_d;

  always_comb begin
    snap_d        = snap_q;
    age_d         = age_q;
    last_change_d = last_change_q;
    stable_d      = stable_q;
    if (load) begin
      snap_d        = vec;
      age_d         = '0;
      last_change_d = '0;
      stable_d      = ST_W'(1);
    end else if (active) begin
      age_d = age_q + CNT_W'(1);
      if (vec == snap_q) begin
        stable_d = stable_q + ST_W'(1);
      end else begin
        snap_d        = vec;
        stable_d      = ST_W'(1);
        last_change_d = age_q + CNT_W'(1);
      end
    end
  end

  // Settling wins over timeout when both land on the same edge.
  assign settled          = active && (stable_d == ST_W'(STABLE_CYCLES));
  assign timed_out        = active && !settled && (age_d == CNT_W'(TIMEOUT));
  assign snap_next        = snap_d;
  assign last_change_next = last_change_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q        <= '0;
      age_q         <= '0;
      last_change_q <= '0;
      stable_q      <= '0;
    end else begin
      snap_q        <= snap_d;
      age_q         <= age_d;
      last_change_q <= last_change_d;
      stable_q      <= stable_d;
    end
  end

endmodule

// File: rtl/alu_result_capture.sv
// Captures the settled outputs of a combinational ALU after each start pulse and offers them,
// with the command and settle latency, over a valid/ready handshake.
module alu_result_capture
  import alu_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 1024,
  parameter int CNT_W         = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       cmd_in,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carryout,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carryout,
  output logic             out_zero,
  output logic             out_overflow,
  output logic [2:0]       out_cmd,
  output logic [CNT_W-1:0] out_latency,
  output logic             out_timeout
);

  cap_state_e       state_q, state_d;
  alu_cmd_e         cmd_q, cmd_d;
  logic [WIDTH-1:0] out_result_q, out_result_d;
  alu_flags_t       out_flags_q, out_flags_d;
  logic [2:0]       out_cmd_q, out_cmd_d;
  logic [CNT_W-1:0] out_latency_q, out_latency_d;
  logic             out_timeout_q, out_timeout_d;
  logic             busy_q, busy_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH+2:0] vec;
  logic [WIDTH+2:0] snap_next;
  logic [CNT_W-1:0] last_change_next;
  logic             settled, timed_out, load, active;

  assign vec    = {alu_result, alu_carryout, alu_zero, alu_overflow};
  assign load   = (state_q == CAP_IDLE) && start;
  assign active = (state_q == CAP_SETTLE);

  stability_tracker #(
    .WIDTH         (WIDTH),
    .STABLE_CYCLES (STABLE_CYCLES),
    .TIMEOUT       (TIMEOUT),
    .CNT_W         (CNT_W)
  ) u_tracker (
    .clk              (clk),
    .rst_n            (rst_n),
    .load             (load),
    .active           (active),
    .vec              (vec),
    .snap_next        (snap_next),
    .last_change_next (last_change_next),
    .settled          (settled),
    .timed_out        (timed_out)
  );

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    out_result_d  = out_result_q;
    out_flags_d   = out_flags_q;
    out_cmd_d     = out_cmd_q;
    out_latency_d = out_latency_q;
    out_timeout_d = out_timeout_q;
    case (state_q)
      CAP_IDLE: begin
        if (start) begin
          state_d = CAP_SETTLE;
          cmd_d   = alu_cmd_e'(cmd_in);
        end
      end
      CAP_SETTLE: begin
        if (settled) begin
          state_d       = CAP_HOLD;
          out_result_d  = snap_next[WIDTH+2:3];
          out_flags_d   = alu_flags_t'(snap_next[2:0]);
          out_cmd_d     = cmd_q;
          out_latency_d = last_change_next;
          out_timeout_d = 1'b0;
        end else if (timed_out) begin
          state_d       = CAP_HOLD;
          out_result_d  = vec[WIDTH+2:3];
          out_flags_d   = alu_flags_t'(vec[2:0]);
          out_cmd_d     = cmd_q;
          out_latency_d = CNT_W'(TIMEOUT);
          out_timeout_d = 1'b1;
        end
      end
      CAP_HOLD: begin
        if (out_ready) state_d = CAP_IDLE;
      end
      default: state_d = CAP_IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they line up with state_q.
  assign busy_d      = (state_d != CAP_IDLE);
  assign out_valid_d = (state_d == CAP_HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= CAP_IDLE;
      cmd_q         <= ALU_ADD;
      out_result_q  <= '0;
      out_flags_q   <= '0;
      out_cmd_q     <= '0;
      out_latency_q <= '0;
      out_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
      out_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      out_result_q  <= out_result_d;
      out_flags_q   <= out_flags_d;
      out_cmd_q     <= out_cmd_d;
      out_latency_q <= out_latency_d;
      out_timeout_q <= out_timeout_d;
      busy_q        <= busy_d;
      out_valid_q   <= out_valid_d;
    end
  end

  assign busy         = busy_q;
  assign out_valid    = out_valid_q;
  assign out_result   = out_result_q;
  assign out_carryout = out_flags_q.carryout;
  assign out_zero     = out_flags_q.zero;
  assign out_overflow = out_flags_q.overflow;
  assign out_cmd      = out_cmd_q;
  assign out_latency  = out_latency_q;
  assign out_timeout  = out_timeout_q;

endmodule

// File: tb/tb_alu_result_capture.sv
// Directed bench for alu_result_capture: the bench plays the ALU and the record consumer.
module tb_alu_result_capture;

  localparam int WIDTH         = 32;
  localparam int STABLE_CYCLES = 4;
  localparam int TIMEOUT       = 16;
  localparam int CNT_W         = $clog2(TIMEOUT + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [2:0]       cmd_in = 3'd0;
  logic [WIDTH-1:0] alu_result = '0;
  logic             alu_carryout = 1'b0;
  logic             alu_zero = 1'b0;
  logic             alu_overflow = 1'b0;
  logic             out_ready = 1'b0;
  logic             busy, out_valid;
  logic [WIDTH-1:0] out_result;
  logic             out_carryout, out_zero, out_overflow;
  logic [2:0]       out_cmd;
  logic [CNT_W-1:0] out_latency;
  logic             out_timeout;

  int checks   = 0;
  int failures = 0;

  alu_result_capture #(
    .WIDTH         (WIDTH),
    .STABLE_CYCLES (STABLE_CYCLES),
    .TIMEOUT       (TIMEOUT),
    .CNT_W         (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .cmd_in       (cmd_in),
    .alu_result   (alu_result),
    .alu_carryout (alu_carryout),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .busy         (busy),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_carryout (out_carryout),
    .out_zero     (out_zero),
    .out_overflow (out_overflow),
    .out_cmd      (out_cmd),
    .out_latency  (out_latency),
    .out_timeout  (out_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [2:0] cmd);
    cmd_in = cmd;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic accept();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({busy, out_valid, out_timeout} !== 3'b000) begin
      failures++;
      $display("FAIL reset_status got busy/valid/timeout=%b required=000", {busy, out_valid, out_timeout});
    end
    checks++;
    if ({out_result, out_carryout, out_zero, out_overflow, out_cmd, out_latency} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got result=%h cmd=%0d lat=%0d required all zero", out_result, out_cmd, out_latency);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_stable_start();
    int c;
    alu_result = 32'h1; alu_carryout = 1'b0; alu_zero = 1'b0; alu_overflow = 1'b0;
    pulse_start(3'd3);
    checks++;
    if ({busy, out_valid} !== 2'b10) begin
      failures++;
      $display("FAIL s1_settling_status got busy/valid=%b required=10", {busy, out_valid});
    end
    wait_valid(c);
    checks++;
    if (c != 3) begin
      failures++;
      $display("FAIL s1_valid_delay got=%0d required=3", c);
    end
    checks++;
    if ({out_result, out_carryout, out_zero, out_overflow, out_cmd, out_latency, out_timeout}
        !== {32'h1, 3'b000, 3'd3, 5'd0, 1'b0}) begin
      failures++;
      $display("FAIL s1_record got result=%h c/z/o=%b%b%b cmd=%0d lat=%0d to=%b required 1 000 3 0 0",
               out_result, out_carryout, out_zero, out_overflow, out_cmd, out_latency, out_timeout);
    end
    accept();
    checks++;
    if ({busy, out_valid} !== 2'b00) begin
      failures++;
      $display("FAIL s1_after_accept got busy/valid=%b required=00", {busy, out_valid});
    end
  endtask

  task automatic test_late_changes();
    int c;
    alu_result = 32'h11; alu_carryout = 1'b0; alu_zero = 1'b0; alu_overflow = 1'b0;
    pulse_start(3'd0);
    alu_result = 32'h22;
    tick();
    alu_result = 32'hFF;
    tick();
    wait_valid(c);
    checks++;
    if (c + 2 != 5) begin
      failures++;
      $display("FAIL s2_valid_delay got=%0d required=5", c + 2);
    end
    checks++;
    if ({out_result, out_latency, out_timeout, out_cmd} !== {32'hFF, 5'd2, 1'b0, 3'd0}) begin
      failures++;
      $display("FAIL s2_record got result=%h lat=%0d to=%b cmd=%0d required ff 2 0 0",
               out_result, out_latency, out_timeout, out_cmd);
    end
    accept();
  endtask

  task automatic test_timeout();
    int c;
    alu_result = 32'hA5A5A5A5; alu_carryout = 1'b0; alu_zero = 1'b0; alu_overflow = 1'b1;
    pulse_start(3'd2);
    c = 0;
    while (out_valid !== 1'b1 && c < 40) begin
      alu_result = ~alu_result;
      tick();
      c++;
    end
    checks++;
    if (c != 16) begin
      failures++;
      $display("FAIL s3_valid_delay got=%0d required=16", c);
    end
    checks++;
    if ({out_timeout, out_latency, out_cmd, out_overflow} !== {1'b1, 5'd16, 3'd2, 1'b1}) begin
      failures++;
      $display("FAIL s3_flags got to=%b lat=%0d cmd=%0d ovf=%b required 1 16 2 1",
               out_timeout, out_latency, out_cmd, out_overflow);
    end
    checks++;
    if (out_result !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL s3_result got=%h required=a5a5a5a5", out_result);
    end
    accept();
  endtask

  task automatic test_backpressure();
    int c;
    alu_result = 32'h1234; alu_carryout = 1'b0; alu_zero = 1'b0; alu_overflow = 1'b0;
    pulse_start(3'd4);
    wait_valid(c);
    checks++;
    if (c != 3) begin
      failures++;
      $display("FAIL s4_valid_delay got=%0d required=3", c);
    end
    for (int i = 0; i < 5; i++) begin
      start      = (i % 2 == 0);
      cmd_in     = 3'd7;
      alu_result = 32'hDEAD0000 + i;
      tick();
      checks++;
      if ({busy, out_valid, out_result, out_cmd} !== {2'b11, 32'h1234, 3'd4}) begin
        failures++;
        $display("FAIL s4_hold_%0d got busy/valid=%b%b result=%h cmd=%0d required 11 1234 4",
                 i, busy, out_valid, out_result, out_cmd);
      end
    end
    start     = 1'b1;
    out_ready = 1'b1;
    tick();
    start     = 1'b0;
    out_ready = 1'b0;
    checks++;
    if ({busy, out_valid, out_result} !== {2'b00, 32'h1234}) begin
      failures++;
      $display("FAIL s4_handshake got busy/valid=%b%b result=%h required 00 1234", busy, out_valid, out_result);
    end
    alu_result = 32'hBEEF;
    pulse_start(3'd7);
    wait_valid(c);
    checks++;
    if (c != 3 || {out_result, out_cmd, out_latency} !== {32'hBEEF, 3'd7, 5'd0}) begin
      failures++;
      $display("FAIL s4_next_capture got delay=%0d result=%h cmd=%0d lat=%0d required 3 beef 7 0",
               c, out_result, out_cmd, out_latency);
    end
  endtask

  task automatic test_mid_reset();
    int c;
    accept();
    alu_result = 32'h55;
    pulse_start(3'd6);
    tick();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL s5_busy_before got=%b required=1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, out_valid, out_result, out_cmd, out_latency} !== '0) begin
      failures++;
      $display("FAIL s5_async_reset got busy/valid=%b%b result=%h cmd=%0d lat=%0d required all zero",
               busy, out_valid, out_result, out_cmd, out_latency);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    alu_result = 32'h1; alu_carryout = 1'b0; alu_zero = 1'b0; alu_overflow = 1'b0;
    pulse_start(3'd3);
    wait_valid(c);
    checks++;
    if (c != 3 || {out_result, out_cmd, out_latency, out_timeout} !== {32'h1, 3'd3, 5'd0, 1'b0}) begin
      failures++;
      $display("FAIL s5_fresh_capture got delay=%0d result=%h cmd=%0d lat=%0d to=%b required 3 1 3 0 0",
               c, out_result, out_cmd, out_latency, out_timeout);
    end
    accept();
  endtask

  task automatic test_sub_zero();
    int c;
    alu_result = 32'h0; alu_carryout = 1'b1; alu_zero = 1'b1; alu_overflow = 1'b0;
    pulse_start(3'd1);
    wait_valid(c);
    checks++;
    if (c != 3) begin
      failures++;
      $display("FAIL s6_valid_delay got=%0d required=3", c);
    end
    checks++;
    if ({out_result, out_zero, out_carryout, out_overflow, out_latency, out_cmd}
        !== {32'h0, 3'b110, 5'd0, 3'd1}) begin
      failures++;
      $display("FAIL s6_record got result=%h z/c/o=%b%b%b lat=%0d cmd=%0d required 0 110 0 1",
               out_result, out_zero, out_carryout, out_overflow, out_latency, out_cmd);
    end
    accept();
  endtask

  initial begin
    test_reset();
    test_stable_start();
    test_late_changes();
    test_timeout();
    test_backpressure();
    test_mid_reset();
    test_sub_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_result_capture.md
Name: alu_result_capture

Overview:
- Response-side companion to the ALU stimulus driver.
- The driver pulses start when it applies operands and command to the combinational ALU.
- This block samples the ALU outputs every clock and waits until all of them have been unchanged for STABLE_CYCLES consecutive samples.
- It then presents the settled result, flags, command and measured settle latency over a valid/ready handshake. A timeout bounds non-settling ALUs.

Parameters:
- WIDTH, 32, ALU operand/result width.
- STABLE_CYCLES, 4, consecutive identical samples required to declare settled (>=2).
- TIMEOUT, 1024, max cycles after start before forced completion.
- CNT_W, $clog2(TIMEOUT+1), latency counter width.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  pulse: ALU inputs were just applied; honoured only in IDLE.
- cmd_in  input  3  ALU command applied with start; recorded for reporting.
- alu_result  input  WIDTH  ALU result.
- alu_carryout  input  1  ALU carryout.
- alu_zero  input  1  ALU zero flag.
- alu_overflow  input  1  ALU overflow flag.
- busy  output  1  high in SETTLE and HOLD.
- out_valid  output  1  captured record available (HOLD).
- out_ready  input  1  consumer accepts record.
- out_result  output  WIDTH  settled result.
- out_carryout, out_zero, out_overflow  output  1 each  settled flags.
- out_cmd  output  3  recorded command.
- out_latency  output  CNT_W  cycles from start to last observed change.
- out_timeout  output  1  record produced by timeout, not settling.

Behaviour:
- Reset (async, rst_n low): state IDLE; busy, out_valid, out_timeout = 0; out_result, flags, out_cmd, out_latency = 0; internal snap/age/stable/last_change = 0. Mid-operation reset aborts with no record emitted.
- vec = {alu_result, alu_carryout, alu_zero, alu_overflow}, WIDTH+3 bits, compared as a whole.
- IDLE, on start:
  - Go to SETTLE.
  - snap <= vec; cmd <= cmd_in.
  - age <= 0; last_change <= 0; stable <= 1.
- SETTLE, each edge:
  - age <= age+1.
  - If vec == snap: stable <= stable+1.
  - Else: snap <= vec; stable <= 1; last_change <= age+1.
- Settled: when the update yields stable == STABLE_CYCLES, go to HOLD with out_* <= snap (new value), out_latency <= last_change, out_timeout <= 0.
  - An ALU already stable at start gives out_valid high STABLE_CYCLES-1 cycles after the start edge, latency 0.
- Timeout: if age+1 == TIMEOUT and the block has not settled on that edge, go to HOLD with out_* <= latest vec, out_latency <= TIMEOUT, out_timeout <= 1. Settling on the same edge takes priority (out_timeout=0).
- HOLD:
  - out_valid = 1; outputs stable until out_valid && out_ready.
  - On that handshake, go to IDLE next edge and drop out_valid.
  - Output registers retain their last value in IDLE.
- start is ignored while busy, including in the handshake cycle. The next start is honoured in IDLE one cycle later.
- Counters saturate by construction: age never exceeds TIMEOUT; stable never exceeds STABLE_CYCLES.
- out_valid and busy are registered state decodes, not combinational from inputs.

Decomposition:
- Package alu_pkg holds:
  - alu_cmd_e 3-bit enum: ADD=0, SUB=1, XOR=2, SLT=3, AND=4, NAND=5, NOR=6, OR=7.
  - The capture state enum: IDLE, SETTLE, HOLD.
  - An alu_flags_t struct: carryout, zero, overflow.
- One sub-module, stability_tracker, is natural: it owns snap/stable/age/last_change and emits settled/timed_out pulses. The top keeps the FSM and the output/handshake registers.

Test Plan:
1. A=0, B=1, cmd=3 (SLT), ALU stable from start, STABLE_CYCLES=4 -> out_valid 3 cycles after start edge; out_result=1, zero=0, carryout=0, overflow=0, out_cmd=3, out_latency=0, out_timeout=0.
2. Bench changes alu_result at start+1 and start+2, then holds 0x0000_00FF -> out_latency=2; out_valid at start+5; out_result=0xFF.
3. TIMEOUT=16, alu_result toggling every cycle -> out_valid at start+16, out_timeout=1, out_latency=16.
4. out_ready held low 5 cycles in HOLD with extra start pulses -> outputs unchanged, busy=1, no new capture; after handshake, the next start is captured normally.
5. rst_n pulsed low mid-SETTLE -> busy, out_valid, outputs all 0 immediately (async); a fresh start then completes as in scenario 1.
6. A=5, B=5, cmd=SUB -> out_result=0, out_zero=1, out_carryout=1, out_overflow=0, out_latency=0.
